// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780 command sequencer.
// State and wait-phase enums, default timings, init command set, slow-opcode test.
package lcd_pkg;

    localparam int TW = 23;

    typedef enum logic [2:0] {
        PWR,
        LOAD,
        SETUP,
        EHIGH,
        EXEC,
        IDLE
    } state_t;

    typedef enum logic [1:0] {
        START,
        GUARD,
        RUN
    } phase_t;

    localparam int unsigned DEF_T_POWERUP = 750000;
    localparam int unsigned DEF_T_SETUP   = 4;
    localparam int unsigned DEF_T_EPULSE  = 25;
    localparam int unsigned DEF_T_EXEC    = 2000;
    localparam int unsigned DEF_T_CLEAR   = 82000;

    localparam int         INIT_CMD_COUNT = 4;
    localparam logic [1:0] INIT_LAST      = 2'(INIT_CMD_COUNT - 1);

    localparam logic [7:0] INIT_FUNC_SET = 8'h38;
    localparam logic [7:0] INIT_DISP_ON  = 8'h0C;
    localparam logic [7:0] INIT_CLEAR    = 8'h01;
    localparam logic [7:0] INIT_ENTRY    = 8'h06;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Clear and home need the long execution wait.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// lcd_init_rom: power-up command table for the LCD, indexed by init step.
// Ports: idx (2-bit step) -> cmd (8-bit opcode, always sent with rs=0).
import lcd_pkg::*;

module lcd_init_rom (
    input  logic [1:0] idx,
    output logic [7:0] cmd
);

    always_comb begin
        cmd = INIT_FUNC_SET;
        case (idx)
            2'd0:    cmd = INIT_FUNC_SET;
            2'd1:    cmd = INIT_DISP_ON;
            2'd2:    cmd = INIT_CLEAR;
            default: cmd = INIT_ENTRY;
        endcase
    end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: runs LCD power-up/init, then writes requested bytes.
// Ports: CLK/RST, in_valid/in_ready/in_rs/in_data request, init_done,
//        timer_rst/timer_wait/timer_busy to the delay timer, lcd_rs/rw/e/data.
import lcd_pkg::*;

module lcd_cmd_sequencer #(
    parameter int unsigned T_POWERUP = DEF_T_POWERUP,
    parameter int unsigned T_SETUP   = DEF_T_SETUP,
    parameter int unsigned T_EPULSE  = DEF_T_EPULSE,
    parameter int unsigned T_EXEC    = DEF_T_EXEC,
    parameter int unsigned T_CLEAR   = DEF_T_CLEAR
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_rs,
    input  logic [7:0]    in_data,
    output logic          init_done,
    output logic          timer_rst,
    output logic [TW-1:0] timer_wait,
    input  logic          timer_busy,
    output logic          lcd_rs,
    output logic          lcd_rw,
    output logic          lcd_e,
    output logic [7:0]    lcd_data
);

    localparam logic [TW-1:0] W_PWR    = TW'(T_POWERUP);
    localparam logic [TW-1:0] W_SETUP  = TW'(T_SETUP);
    localparam logic [TW-1:0] W_EPULSE = TW'(T_EPULSE);
    localparam logic [TW-1:0] W_EXEC   = TW'(T_EXEC);
    localparam logic [TW-1:0] W_CLEAR  = TW'(T_CLEAR);

    state_t        state;
    phase_t        phase;
    logic          guard_cnt;
    logic [1:0]    init_idx;
    logic          req_rs;
    logic [7:0]    req_data;
    logic [7:0]    rom_cmd;
    logic [TW-1:0] exec_wait;
    logic [TW-1:0] cur_wait;
    logic          waiting;
    logic          wait_done;

    lcd_init_rom u_rom (
        .idx (init_idx),
        .cmd (rom_cmd)
    );

    assign lcd_rw = 1'b0;

    // Bus contents are frozen from LOAD, so the exec wait can be
    // derived from what is already on the bus.
    assign exec_wait = is_slow_cmd(lcd_rs, lcd_data) ? W_CLEAR : W_EXEC;

    always_comb begin
        cur_wait = '0;
        case (state)
            PWR:     cur_wait = W_PWR;
            SETUP:   cur_wait = W_SETUP;
            EHIGH:   cur_wait = W_EPULSE;
            EXEC:    cur_wait = exec_wait;
            default: cur_wait = '0;
        endcase
    end

    assign waiting = (state == PWR) || (state == SETUP) ||
                     (state == EHIGH) || (state == EXEC);

    // The timer flag only becomes meaningful after the guard cycles.
    assign wait_done = (phase == RUN) && !timer_busy;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= PWR;
            phase      <= START;
            guard_cnt  <= 1'b0;
            init_idx   <= 2'd0;
            init_done  <= 1'b0;
            in_ready   <= 1'b0;
            req_rs     <= 1'b0;
            req_data   <= 8'h00;
            timer_rst  <= 1'b1;
            timer_wait <= '0;
            lcd_rs     <= 1'b0;
            lcd_e      <= 1'b0;
            lcd_data   <= 8'h00;
        end else begin
            // Wait sub-phases; a state transition below may restart them.
            if (waiting) begin
                case (phase)
                    START: begin
                        timer_rst  <= 1'b0;
                        timer_wait <= cur_wait;
                        guard_cnt  <= 1'b0;
                        phase      <= GUARD;
                    end
                    GUARD: begin
                        guard_cnt <= 1'b1;
                        if (guard_cnt) begin
                            phase <= RUN;
                        end
                    end
                    default: ;
                endcase
            end

            case (state)
                PWR: begin
                    if (wait_done) begin
                        timer_rst <= 1'b1;
                        init_idx  <= 2'd0;
                        state     <= LOAD;
                    end
                end

                LOAD: begin
                    lcd_rs     <= init_done ? req_rs : 1'b0;
                    lcd_data   <= init_done ? req_data : rom_cmd;
                    timer_rst  <= 1'b1;
                    timer_wait <= W_SETUP;
                    phase      <= START;
                    state      <= SETUP;
                end

                SETUP: begin
                    if (wait_done) begin
                        lcd_e      <= 1'b1;
                        timer_rst  <= 1'b1;
                        timer_wait <= W_EPULSE;
                        phase      <= START;
                        state      <= EHIGH;
                    end
                end

                EHIGH: begin
                    if (wait_done) begin
                        lcd_e      <= 1'b0;
                        timer_rst  <= 1'b1;
                        timer_wait <= exec_wait;
                        phase      <= START;
                        state      <= EXEC;
                    end
                end

                EXEC: begin
                    if (wait_done) begin
                        timer_rst <= 1'b1;
                        if (!init_done && (init_idx != INIT_LAST)) begin
                            init_idx <= init_idx + 2'd1;
                            state    <= LOAD;
                        end else begin
                            init_done <= 1'b1;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end

                IDLE: begin
                    if (in_valid && in_ready) begin
                        req_rs   <= in_rs;
                        req_data <= in_data;
                        in_ready <= 1'b0;
                        state    <= LOAD;
                    end
                end

                default: begin
                    state <= PWR;
                    phase <= START;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer: scoreboard bench for the LCD command sequencer.
// Two instances with behavioural delay timers; one uses a zero setup wait.
`timescale 1ns/1ps

module tb_lcd_cmd_sequencer;

    typedef struct {
        logic       rs;
        logic [7:0] data;
    } byte_t;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         min_exec;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_rs = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic        in_ready, init_done, timer_rst, lcd_rs, lcd_rw, lcd_e;
    logic [22:0] timer_wait;
    logic [7:0]  lcd_data;
    logic        tflag;
    logic [22:0] tcnt;

    logic        ready0, done0, trst0, rs0, rw0, e0;
    logic [22:0] twait0;
    logic [7:0]  data0;
    logic        tflag0;
    logic [22:0] tcnt0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    byte_t sb_q[$];
    byte_t mon_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_cmd_sequencer #(
        .T_POWERUP (100),
        .T_SETUP   (4),
        .T_EPULSE  (25),
        .T_EXEC    (50),
        .T_CLEAR   (200)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs      (in_rs),
        .in_data    (in_data),
        .init_done  (init_done),
        .timer_rst  (timer_rst),
        .timer_wait (timer_wait),
        .timer_busy (tflag),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_e      (lcd_e),
        .lcd_data   (lcd_data)
    );

    lcd_cmd_sequencer #(
        .T_POWERUP (100),
        .T_SETUP   (0),
        .T_EPULSE  (25),
        .T_EXEC    (50),
        .T_CLEAR   (200)
    ) dut0 (
        .CLK        (clk),
        .RST        (rst),
        .in_valid   (1'b0),
        .in_ready   (ready0),
        .in_rs      (1'b0),
        .in_data    (8'h00),
        .init_done  (done0),
        .timer_rst  (trst0),
        .timer_wait (twait0),
        .timer_busy (tflag0),
        .lcd_rs     (rs0),
        .lcd_rw     (rw0),
        .lcd_e      (e0),
        .lcd_data   (data0)
    );

    // Delay timer models: flag is 0 in the cycle after reset release,
    // then high while fewer than wait_time cycles have elapsed.
    always @(posedge clk) begin
        if (timer_rst) begin
            tcnt  <= '0;
            tflag <= 1'b0;
        end else begin
            tcnt  <= tcnt + 23'd1;
            tflag <= ((tcnt + 23'd1) < timer_wait);
        end
    end

    always @(posedge clk) begin
        if (trst0) begin
            tcnt0  <= '0;
            tflag0 <= 1'b0;
        end else begin
            tcnt0  <= tcnt0 + 23'd1;
            tflag0 <= ((tcnt0 + 23'd1) < twait0);
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, got, got, exp, exp);
        end
    endtask

    task automatic check_min(input string name, input int got, input int lo);
        n_cmp++;
        if (got < lo) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected >= %0d", name, got, lo);
        end
    endtask

    task automatic check_range(input string name, input int got,
                               input int lo, input int hi);
        n_cmp++;
        if (got < lo || got > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    function automatic int exec_min(input logic rs, input logic [7:0] d);
        return (!rs && (d == 8'h01 || d == 8'h02)) ? 200 : 50;
    endfunction

    function automatic logic [7:0] init_cmd(input int i);
        case (i)
            0:       return 8'h38;
            1:       return 8'h0C;
            2:       return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Monitor for the main instance
    logic       pe;
    int         rise_c, fall_c, chg_c, next_gap, pulses, rel_cyc;
    bit         have_fall, first_rise;
    logic [8:0] prev_bus, rise_bus;

    always @(negedge clk) begin
        if (rst) begin
            pe         = 1'b0;
            have_fall  = 1'b0;
            first_rise = 1'b1;
            pulses     = 0;
            chg_c      = cyc;
            prev_bus   = {lcd_rs, lcd_data};
            sb_q.delete();
        end else begin
            if ({lcd_rs, lcd_data} != prev_bus) chg_c = cyc;
            prev_bus = {lcd_rs, lcd_data};
            if (!init_done) check("ready_during_init", int'(in_ready), 0);
            if (lcd_e && pe)
                check("bus_stable_e_high", int'({lcd_rs, lcd_data}), int'(rise_bus));
            if (lcd_e && !pe) begin
                pulses++;
                rise_c   = cyc;
                rise_bus = {lcd_rs, lcd_data};
                check_min("setup_before_e", cyc - chg_c, 4);
                if (first_rise) begin
                    check_min("powerup_delay", cyc - rel_cyc, 104);
                    first_rise = 1'b0;
                end
                if (have_fall) check_min("exec_gap", cyc - fall_c, next_gap);
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: got rs=%0d data=0x%0h, expected none",
                             lcd_rs, lcd_data);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check("pulse_rs", int'(lcd_rs), int'(mon_exp.rs));
                    check("pulse_data", int'(lcd_data), int'(mon_exp.data));
                end
            end
            if (!lcd_e && pe) begin
                check_range("e_width", cyc - rise_c, 25, 27);
                check("rw_low", int'(lcd_rw), 0);
                fall_c    = cyc;
                have_fall = 1'b1;
                next_gap  = exec_min(lcd_rs, lcd_data);
            end
            pe = lcd_e;
        end
    end

    // Monitor for the zero-setup instance
    logic pe0;
    int   n0, fall0;

    always @(negedge clk) begin
        if (rst) begin
            pe0 = 1'b0;
            n0  = 0;
        end else begin
            if (e0 && !pe0) begin
                if (n0 < 4) check("zw_data", int'(data0), int'(init_cmd(n0)));
                if (n0 == 1) check_range("zw_gap", cyc - fall0, 55, 59);
                n0++;
            end
            if (!e0 && pe0) fall0 = cyc;
            pe0 = e0;
        end
    end

    task automatic wait_ready(input int budget, input string name);
        int k = 0;
        while (!in_ready && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: in_ready=%0d after %0d cycles, expected 1",
                     name, in_ready, budget);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_timer_rst", int'(timer_rst), 1);
        check("rst_timer_wait", int'(timer_wait), 0);
        check("rst_lcd_e", int'(lcd_e), 0);
        check("rst_lcd_rs", int'(lcd_rs), 0);
        check("rst_lcd_data", int'(lcd_data), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_init_done", int'(init_done), 0);
        check("rst_lcd_rw", int'(lcd_rw), 0);
        @(negedge clk);
        rst     = 1'b0;
        rel_cyc = cyc;
        @(negedge clk);
        for (int i = 0; i < 4; i++) sb_q.push_back('{1'b0, init_cmd(i)});
    endtask

    task automatic send(input logic rs, input logic [7:0] d, input int min_exec);
        @(negedge clk);
        in_valid = 1'b1;
        in_rs    = rs;
        in_data  = d;
        wait_ready(5000, "accept_timeout");
        check("accept_after_init", int'(init_done), 1);
        sb_q.push_back('{rs, d});
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("ready_drop", int'(in_ready), 0);
        wait_ready(5000, "ready_return");
        check_min("exec_before_ready", cyc - fall_c, min_exec);
    endtask

    vec_t vecs[6];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 8'h41, 50};
        vecs[1] = '{1'b0, 8'h01, 200};
        vecs[2] = '{1'b1, 8'h7E, 50};
        vecs[3] = '{1'b0, 8'h02, 200};
        vecs[4] = '{1'b0, 8'h80, 50};
        vecs[5] = '{1'b1, 8'h20, 50};

        do_reset();

        // Request raised during init is held off until init completes.
        send(1'b1, 8'h55, 50);
        check("init_plus_one_pulse", pulses, 5);
        check("queue_drained_early", sb_q.size(), 0);
        check("zw_init_done", int'(done0), 1);
        check("zw_pulses", n0, 4);

        for (int i = 0; i < 6; i++)
            send(vecs[i].rs, vecs[i].data, vecs[i].min_exec);
        check("table_pulses", pulses, 11);

        // Back-to-back: valid stays high across two transfers.
        @(negedge clk);
        in_valid = 1'b1;
        in_rs    = 1'b1;
        in_data  = 8'h48;
        wait_ready(5000, "b2b_first");
        sb_q.push_back('{1'b1, 8'h48});
        @(posedge clk);
        #1 in_data = 8'h49;
        @(negedge clk);
        check("b2b_ready_drop", int'(in_ready), 0);
        wait_ready(5000, "b2b_second");
        sb_q.push_back('{1'b1, 8'h49});
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        wait_ready(5000, "b2b_done");
        check("b2b_pulses", pulses, 13);
        check("b2b_queue_empty", sb_q.size(), 0);

        // Reset while E is high for a captured request.
        @(negedge clk);
        in_valid = 1'b1;
        in_rs    = 1'b1;
        in_data  = 8'h5A;
        wait_ready(5000, "mid_accept");
        sb_q.push_back('{1'b1, 8'h5A});
        @(posedge clk);
        #1 in_valid = 1'b0;
        begin
            int k = 0;
            while (!lcd_e && k < 200) begin
                @(negedge clk);
                k++;
            end
            check("mid_e_seen", int'(lcd_e), 1);
        end
        #2 rst = 1'b1;
        #1;
        check("async_lcd_e", int'(lcd_e), 0);
        check("async_timer_rst", int'(timer_rst), 1);
        do_reset();
        wait_ready(5000, "reinit_done");
        check("reinit_pulses", pulses, 4);
        check("reinit_init_done", int'(init_done), 1);
        repeat (100) @(negedge clk);
        check("request_lost", pulses, 4);
        check("reinit_queue_empty", sb_q.size(), 0);
        check("zw_reinit_pulses", n0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_sequencer.md
Name: lcd_cmd_sequencer

Overview:
- Sits directly upstream of the `clock_devide` delay timer and drives the character LCD (HD44780-style, 8-bit bus, write-only).
- After reset, runs the power-up/init sequence, then accepts byte write requests from the application over a valid/ready handshake.
- Every bus cycle (RS setup, E pulse, execution wait) is timed by the external `clock_devide` instance: this block drives `timer_rst`/`timer_wait` into it and consumes its `flag_xs` output as `timer_busy`.

Parameters:
- T_POWERUP, 750000, power-on wait in CLK cycles (15 ms at 50 MHz); must be < 2^23.
- T_SETUP, 4, RS/data setup before E rises.
- T_EPULSE, 25, E high time.
- T_EXEC, 2000, execution wait for normal commands and data (40 us).
- T_CLEAR, 82000, execution wait for clear/home commands (rs=0, data 0x01 or 0x02).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- in_valid  in  1  write request valid.
- in_ready  out  1  block can accept a request (IDLE only).
- in_rs  in  1  0=command, 1=data.
- in_data  in  8  byte to write.
- init_done  out  1  init sequence complete; stays 1 until reset.
- timer_rst  out  1  drives `clock_devide.flag_rst`.
- timer_wait  out  23  drives `clock_devide.wait_time`.
- timer_busy  in  1  `clock_devide.flag_xs`; 1 = interval still running.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  constant 0 (write only).
- lcd_e  out  1  LCD enable strobe.
- lcd_data  out  8  LCD data bus.

Behaviour:
- Reset values (asynchronous): timer_rst=1, timer_wait=0, lcd_e=0, lcd_rs=0, lcd_data=0x00, in_ready=0, init_done=0, state=PWR, init_idx=0.
- Timed wait primitive, used by every state:
  - Cycle 0: timer_rst=1 and timer_wait=W, both registered.
  - Next 2 cycles: GUARD. timer_rst=0 and timer_busy is ignored, because the timer's flag is still 0 for one cycle after its reset is released.
  - After GUARD: wait until timer_busy=0 is sampled.
  - Total latency: W+3 cycles ±1.
  - W=0 must complete via GUARD only; no hang.
  - timer_wait is held stable for the whole interval.
- The timer counter wraps at 2^23, so done must be acted on in the first cycle it is seen.
- Between waits timer_rst is held 1, which keeps the timer cleared.
- States:
  - PWR: wait T_POWERUP, then go to LOAD with init_idx=0.
  - LOAD: latch rs/data onto lcd_rs/lcd_data (init ROM entry if init_done=0, else the captured request); start T_SETUP; go to SETUP.
  - SETUP: on done, lcd_e=1, start T_EPULSE, go to EHIGH.
  - EHIGH: on done, lcd_e=0, start T_CLEAR if rs=0 and data∈{0x01,0x02}, else T_EXEC; go to EXEC.
  - EXEC: on done, if init_done=0 and init_idx<3, increment init_idx and go to LOAD. If init_idx=3, set init_done=1 and go to IDLE. Otherwise go to IDLE.
  - IDLE: in_ready=1. If in_valid, capture in_rs/in_data in the same cycle, drop in_ready next cycle, go to LOAD.
- Init ROM, all rs=0: 0x38 (8-bit, 2 lines), 0x0C (display on), 0x01 (clear), 0x06 (entry mode).
- lcd_rs and lcd_data stay stable from LOAD until EXEC completes. This covers hold time after E falls.
- Handshake:
  - Transfer occurs when in_valid && in_ready.
  - in_ready=0 in all states except IDLE, including during init.
  - Requests presented before init_done are held off, not dropped.
- Reset asserted mid-operation: lcd_e drops immediately; the sequence restarts from PWR (full power-up wait and init are re-run); any captured request is discarded.

Decomposition:
- Package `lcd_pkg`: state enum (PWR, LOAD, SETUP, EHIGH, EXEC, IDLE), wait sub-phase enum (START, GUARD, RUN), default timing constants, init command values and count (4), clear/home opcodes.
- One sub-module, `lcd_init_rom`: combinational, 2-bit index to 8-bit command.
- `clock_devide` is instantiated beside this block at the LCD top level, not inside it.

Test Plan:
- Init sequence, with T_POWERUP=100, T_SETUP=4, T_EPULSE=25, T_EXEC=50, T_CLEAR=200 and a real `clock_devide` attached:
  - Release RST; the first E rise occurs ≥104 cycles after release.
  - E pulses show data 0x38, 0x0C, 0x01, 0x06 in order, each E high 25–27 cycles.
  - The gap after 0x01's E fall is ≥200 cycles; other gaps are ≥50.
  - init_done rises after the last EXEC.
- Data write: in_valid with rs=1, data=0x41 while in IDLE:
  - Accepted that cycle, in_ready falls next cycle.
  - lcd_rs=1 and lcd_data=0x41 precede E by ≥4 cycles.
  - in_ready returns after ≥50 cycles of EXEC.
- Early request: in_valid held from cycle 1 after reset with data=0x55 → not accepted until init_done=1; exactly one E pulse carries 0x55.
- Zero wait: T_SETUP=0 → the sequence still progresses; E rises 3±1 cycles after LOAD, with no deadlock.
- Reset mid-pulse: assert RST while lcd_e=1 → lcd_e=0 and timer_rst=1 asynchronously. After release, a full power-up and 4-command init repeat; the pending request is lost.
- Back-to-back requests: in_valid held with 0x48 then 0x49 → two separate transfers with no overlap of E or the EXEC window; lcd_data never changes while lcd_e=1.
